// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix operand feeder: word width, feeder
// state encoding and an index-width helper that never returns zero.
package matrix_pkg;

    localparam int WORD_WIDTH = 32;

    typedef enum logic [1:0] {
        LOAD,
        PRESENT,
        WAIT_DROP,
        DONE
    } feeder_state_t;

    // Width needed to index n items; a single item still gets one bit.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/matrix_operand_store.sv
// Register file holding A (slots 0..N*N-1) and B (slots N*N..2*N*N-1),
// both row-major. One write port; row i of A and column j of B are read
// combinationally as packed vectors, element k at bits [32k+31:32k].
module matrix_operand_store
    import matrix_pkg::*;
#(
    parameter  int N  = 4,
    localparam int AW = idx_width(2 * N * N),
    localparam int IW = idx_width(N)
) (
    input  logic                    clk,
    input  logic                    wr_en,
    input  logic [AW-1:0]           wr_addr,
    input  logic [WORD_WIDTH-1:0]   wr_data,
    input  logic [IW-1:0]           rd_i,
    input  logic [IW-1:0]           rd_j,
    output logic [WORD_WIDTH*N-1:0] row,
    output logic [WORD_WIDTH*N-1:0] column
);

    logic [WORD_WIDTH-1:0] mem [2*N*N];

    // Storage is deliberately not reset; the feeder overwrites it every job.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Gather row i of A and column j of B into packed output vectors.
    always_comb begin
        row    = '0;
        column = '0;
        for (int k = 0; k < N; k++) begin
            row[k*WORD_WIDTH +: WORD_WIDTH]    = mem[AW'(int'(rd_i) * N + k)];
            column[k*WORD_WIDTH +: WORD_WIDTH] = mem[AW'(N * N + k * N + int'(rd_j))];
        end
    end

endmodule

// File: rtl/matrix_operand_feeder.sv
// Operand feeder for inner_product: loads A then B from a word stream,
// then issues every (row i of A, column j of B) pair in row-major order of C
// over a four-phase stb/ack handshake, publishing (i,j) alongside.
// Optional feature: define MATRIX_FEEDER_KEEP_B_EN to keep B loaded across
// jobs (a b_valid flag, cleared only by rst, limits later loads to A only).
module matrix_operand_feeder
    import matrix_pkg::*;
#(
    parameter  int N  = 4,
    localparam int IW = idx_width(N)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [WORD_WIDTH-1:0]   in_data,
    input  logic                    in_i_stb,
    output logic                    in_i_ack,
    output logic [WORD_WIDTH*N-1:0] row,
    output logic                    row_o_stb,
    input  logic                    row_i_ack,
    output logic [WORD_WIDTH*N-1:0] column,
    output logic                    column_o_stb,
    input  logic                    column_i_ack,
    output logic [IW-1:0]           pair_i,
    output logic [IW-1:0]           pair_j,
    output logic                    done
);

    localparam int            AW          = idx_width(2 * N * N);
    localparam logic [IW-1:0] LAST_IDX    = IW'(N - 1);
    localparam logic [AW-1:0] LAST_B_WORD = AW'(2 * N * N - 1);
`ifdef MATRIX_FEEDER_KEEP_B_EN
    localparam logic [AW-1:0] LAST_A_WORD = AW'(N * N - 1);
`endif

    feeder_state_t state_q, state_d;
    logic [AW-1:0] wcnt_q, wcnt_d;
    logic [IW-1:0] i_q, i_d;
    logic [IW-1:0] j_q, j_d;
    logic          row_stb_q, row_stb_d;
    logic          col_stb_q, col_stb_d;
    logic          ack_q, ack_d;
    logic          xfer;
    logic          last_word;
    logic          show_pair;
    logic [WORD_WIDTH*N-1:0] store_row;
    logic [WORD_WIDTH*N-1:0] store_column;

`ifdef MATRIX_FEEDER_KEEP_B_EN
    logic b_valid_q, b_valid_d;
    assign last_word = b_valid_q ? (wcnt_q == LAST_A_WORD) : (wcnt_q == LAST_B_WORD);
`else
    assign last_word = (wcnt_q == LAST_B_WORD);
`endif

    assign xfer         = in_i_stb & ack_q;
    assign in_i_ack     = ack_q;
    assign row_o_stb    = row_stb_q;
    assign column_o_stb = col_stb_q;
    assign pair_i       = i_q;
    assign pair_j       = j_q;
    assign done         = (state_q == DONE);

    // Outputs read zero outside the issue phase so reset never exposes stale storage.
    assign show_pair = (state_q == PRESENT) || (state_q == WAIT_DROP);
    assign row       = show_pair ? store_row    : '0;
    assign column    = show_pair ? store_column : '0;

    matrix_operand_store #(.N(N)) u_store (
        .clk     (clk),
        .wr_en   (xfer),
        .wr_addr (wcnt_q),
        .wr_data (in_data),
        .rd_i    (i_q),
        .rd_j    (j_q),
        .row     (store_row),
        .column  (store_column)
    );

    // State, counters and handshake flags; rst aborts any job in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= LOAD;
            wcnt_q    <= '0;
            i_q       <= '0;
            j_q       <= '0;
            row_stb_q <= 1'b0;
            col_stb_q <= 1'b0;
            ack_q     <= 1'b0;
`ifdef MATRIX_FEEDER_KEEP_B_EN
            b_valid_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            i_q       <= i_d;
            j_q       <= j_d;
            row_stb_q <= row_stb_d;
            col_stb_q <= col_stb_d;
            ack_q     <= ack_d;
`ifdef MATRIX_FEEDER_KEEP_B_EN
            b_valid_q <= b_valid_d;
`endif
        end
    end

    // Next-state logic: load words, present pairs, wait for four-phase ack drop.
    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        i_d       = i_q;
        j_d       = j_q;
        row_stb_d = row_stb_q;
        col_stb_d = col_stb_q;
`ifdef MATRIX_FEEDER_KEEP_B_EN
        b_valid_d = b_valid_q;
`endif
        unique case (state_q)
            LOAD: begin
                if (xfer) begin
                    wcnt_d = wcnt_q + 1'b1;
`ifdef MATRIX_FEEDER_KEEP_B_EN
                    if (wcnt_q == LAST_B_WORD) begin
                        b_valid_d = 1'b1;
                    end
`endif
                    if (last_word) begin
                        state_d   = PRESENT;
                        wcnt_d    = '0;
                        i_d       = '0;
                        j_d       = '0;
                        row_stb_d = 1'b1;
                        col_stb_d = 1'b1;
                    end
                end
            end
            PRESENT: begin
                if (row_stb_q && row_i_ack) begin
                    row_stb_d = 1'b0;
                end
                if (col_stb_q && column_i_ack) begin
                    col_stb_d = 1'b0;
                end
                if (!row_stb_d && !col_stb_d) begin
                    state_d = WAIT_DROP;
                end
            end
            WAIT_DROP: begin
                if (!row_i_ack && !column_i_ack) begin
                    if (i_q == LAST_IDX && j_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        if (j_q == LAST_IDX) begin
                            j_d = '0;
                            i_d = i_q + 1'b1;
                        end else begin
                            j_d = j_q + 1'b1;
                        end
                        row_stb_d = 1'b1;
                        col_stb_d = 1'b1;
                        state_d   = PRESENT;
                    end
                end
            end
            DONE: begin
                state_d = LOAD;
                i_d     = '0;
                j_d     = '0;
            end
            default: begin
                state_d = LOAD;
            end
        endcase
        ack_d = (state_d == LOAD);
    end

endmodule

// File: tb/tb_matrix_operand_feeder.sv
// Self-checking bench for matrix_operand_feeder (N=2, default build).
// A behavioural model (plain A/B arrays plus the index of the pair being
// issued) supplies expected row/column/coordinates; the driver checks the
// handshake timing cycle by cycle from the stb/ack rules.
module tb_matrix_operand_feeder;
    import matrix_pkg::*;

    localparam int N  = 2;
    localparam int IW = idx_width(N);
    localparam int RW = WORD_WIDTH * N;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [WORD_WIDTH-1:0] in_data = '0;
    logic                  in_i_stb = 1'b0;
    logic                  in_i_ack;
    logic [RW-1:0]         row;
    logic                  row_o_stb;
    logic                  row_i_ack = 1'b0;
    logic [RW-1:0]         column;
    logic                  column_o_stb;
    logic                  column_i_ack = 1'b0;
    logic [IW-1:0]         pair_i;
    logic [IW-1:0]         pair_j;
    logic                  done;

    int vectors     = 0;
    int miscompares = 0;
    int cur_pair    = 0;
    logic [WORD_WIDTH-1:0] a_m [N][N];
    logic [WORD_WIDTH-1:0] b_m [N][N];

    always #5 clk = ~clk;

    matrix_operand_feeder #(.N(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_i_stb     (in_i_stb),
        .in_i_ack     (in_i_ack),
        .row          (row),
        .row_o_stb    (row_o_stb),
        .row_i_ack    (row_i_ack),
        .column       (column),
        .column_o_stb (column_o_stb),
        .column_i_ack (column_i_ack),
        .pair_i       (pair_i),
        .pair_j       (pair_j),
        .done         (done)
    );

    function automatic logic [RW-1:0] expRow(input int i);
        logic [RW-1:0] r;
        for (int k = 0; k < N; k++) r[k*WORD_WIDTH +: WORD_WIDTH] = a_m[i][k];
        return r;
    endfunction

    function automatic logic [RW-1:0] expCol(input int j);
        logic [RW-1:0] r;
        for (int k = 0; k < N; k++) r[k*WORD_WIDTH +: WORD_WIDTH] = b_m[k][j];
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic checkBit(input string name, input logic act, input logic exp);
        checkOutput(name, RW'(act), RW'(exp));
    endtask

    // Every cycle a pair is offered, it must match the model's current pair.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && (row_o_stb || column_o_stb)) begin
                if (cur_pair < N * N) begin
                    checkOutput("row data", row, expRow(cur_pair / N));
                    checkOutput("column data", column, expCol(cur_pair % N));
                    checkOutput("pair_i", RW'(pair_i), RW'(cur_pair / N));
                    checkOutput("pair_j", RW'(pair_j), RW'(cur_pair % N));
                end else begin
                    checkBit("stb after last pair", 1'b1, 1'b0);
                end
            end
        end
    end

    // One load word: offer it, expect the feeder ready, then idle gap cycles.
    task automatic applyStimulus(input logic [WORD_WIDTH-1:0] w, input int gap);
        int waited;
        in_data  = w;
        in_i_stb = 1'b1;
        @(negedge clk);
        checkBit("load ready", in_i_ack, 1'b1);
        waited = 0;
        while (!in_i_ack && waited < 20) begin
            @(posedge clk); #1;
            @(negedge clk);
            waited++;
        end
        if (!in_i_ack) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL load timeout: in_i_ack stayed 0, expected 1");
        end
        @(posedge clk); #1;
        in_i_stb = 1'b0;
        in_data  = $urandom;
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            checkBit("load gap ready", in_i_ack, 1'b1);
            @(posedge clk); #1;
        end
    endtask

    task automatic loadJob(input bit randomize, input bit gaps);
        int idx;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                a_m[r][c] = randomize ? $urandom : 32'(r * N + c + 1);
                b_m[r][c] = randomize ? $urandom : 32'(32'h11 + r * N + c);
            end
        end
        cur_pair = 0;
        idx = 0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                applyStimulus(a_m[r][c], gaps ? 1 : 0);
                idx++;
            end
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                idx++;
                applyStimulus(b_m[r][c], (gaps && idx != 2 * N * N) ? 1 : 0);
            end
    endtask

    // Consumer for one pair: row ack rises in cycle ra, column ack in cycle ca,
    // both held for h extra cycles after the later one, then dropped together.
    task automatic servePair(input int ra, input int ca, input int h,
                             input logic [1:0] use_lit,
                             input logic [RW-1:0] lit_row, input logic [RW-1:0] lit_col);
        int d;
        d = ((ra > ca) ? ra : ca) + 1 + h;
        for (int c = 0; c <= d; c++) begin
            row_i_ack    = (c >= ra) && (c < d);
            column_i_ack = (c >= ca) && (c < d);
            @(negedge clk);
            checkBit("row_o_stb", row_o_stb, c <= ra);
            checkBit("column_o_stb", column_o_stb, c <= ca);
            checkBit("in_i_ack busy", in_i_ack, 1'b0);
            checkBit("done idle", done, 1'b0);
            if (c == 0 && use_lit[1]) checkOutput("literal row", row, lit_row);
            if (c == 0 && use_lit[0]) checkOutput("literal column", column, lit_col);
            @(posedge clk); #1;
        end
        row_i_ack    = 1'b0;
        column_i_ack = 1'b0;
        cur_pair++;
    endtask

    task automatic servePairRandom();
        servePair($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), 2'b00, '0, '0);
    endtask

    task automatic finishJob();
        @(negedge clk);
        checkBit("done pulse", done, 1'b1);
        checkBit("row_o_stb at done", row_o_stb, 1'b0);
        checkBit("column_o_stb at done", column_o_stb, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        checkBit("done single cycle", done, 1'b0);
        checkBit("reload ready", in_i_ack, 1'b1);
        @(posedge clk); #1;
    endtask

    task automatic checkResetValues(input string tag);
        checkBit({tag, " row_o_stb"}, row_o_stb, 1'b0);
        checkBit({tag, " column_o_stb"}, column_o_stb, 1'b0);
        checkBit({tag, " done"}, done, 1'b0);
        checkBit({tag, " in_i_ack"}, in_i_ack, 1'b0);
        checkOutput({tag, " pair_i"}, RW'(pair_i), '0);
        checkOutput({tag, " pair_j"}, RW'(pair_j), '0);
        checkOutput({tag, " row"}, row, '0);
        checkOutput({tag, " column"}, column, '0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Power-on reset and the cycle after it deasserts.
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        checkResetValues("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checkBit("ack before first edge", in_i_ack, 1'b0);
        @(posedge clk); #1;

        // Job 1: fixed data, acks pulsed one cycle after each stb.
        loadJob(1'b0, 1'b0);
        servePair(1, 1, 0, 2'b11, 64'h00000002_00000001, 64'h00000013_00000011);
        servePair(1, 1, 0, 2'b01, '0, 64'h00000014_00000012);
        servePair(1, 1, 0, 2'b10, 64'h00000004_00000003, '0);
        servePair(1, 1, 0, 2'b00, '0, '0);
        finishJob();

        // Job 2: load with gaps, staggered acks, acks held high 5 cycles.
        loadJob(1'b1, 1'b1);
        servePair(1, 4, 0, 2'b00, '0, '0);
        servePair(0, 0, 5, 2'b00, '0, '0);
        servePair(0, 0, 0, 2'b00, '0, '0);
        servePair(3, 0, 2, 2'b00, '0, '0);
        finishJob();

        // Job 3: reset while pair (1,0) is presented, then restart from (0,0).
        loadJob(1'b1, 1'b0);
        servePairRandom();
        servePairRandom();
        rst = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checkResetValues("mid reset");
        @(posedge clk); #1;
        loadJob(1'b1, 1'b0);
        for (int p = 0; p < N * N; p++) servePairRandom();
        finishJob();

        // Further randomized jobs.
        for (int job = 0; job < 3; job++) begin
            loadJob(1'b1, 1'($urandom_range(0, 1)));
            for (int p = 0; p < N * N; p++) servePairRandom();
            finishJob();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/matrix_operand_feeder.md
# matrix_operand_feeder

Upstream operand stage for the `inner_product` unit. Loads matrices A and B (N×N, 32-bit words, row-major) from a word stream into local storage. Then issues every (row i of A, column j of B) pair to `inner_product` over its stb/ack handshake, in row-major order of C. Alongside each pair it publishes the C coordinates so the result collector can place the dot product.

## Interface
- `N`, 4, matrix dimension (≥1); vectors are N words.
- `WORD_WIDTH`, 32, element width; fixed by package.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_data`  in  32  load word; A row-major, then B row-major.
- `in_i_stb`  in  1  load word valid.
- `in_i_ack`  out  1  feeder ready for load words; a word transfers when `in_i_stb & in_i_ack`.
- `row`  out  32*N  row i of A; element k at bits [32k+31:32k].
- `row_o_stb`  out  1  row valid.
- `row_i_ack`  in  1  consumer acknowledge for row.
- `column`  out  32*N  column j of B; element k is B[k][j], same packing.
- `column_o_stb`  out  1  column valid.
- `column_i_ack`  in  1  consumer acknowledge for column.
- `pair_i`, `pair_j`  out  $clog2(N) (min 1)  C coordinates of the presented pair.
- `done`  out  1  one-cycle pulse after the last pair's acks have dropped.

## Operation
- States: LOAD, PRESENT, WAIT_DROP, DONE.
- LOAD:
  - `in_i_ack`=1; each transfer writes the next storage slot.
  - Slots 0..N²-1 are A[r][c], slot r*N+c. Slots N²..2N²-1 are B.
  - `in_i_stb` gaps are allowed.
  - On the transfer of the last word, go to PRESENT with i=j=0 and both stbs set.
- PRESENT:
  - `row`, `column`, `pair_i`, `pair_j` are stable while either stb is high.
  - Each stb clears independently on the edge where it and its ack are both high.
  - When both are cleared, go to WAIT_DROP.
- WAIT_DROP (four-phase; the consumer holds ack high across its computation):
  - Wait until `row_i_ack`=0 and `column_i_ack`=0 are sampled in the same cycle.
  - If (i,j)=(N-1,N-1), go to DONE.
  - Otherwise j++; on wrap, j=0 and i++. Set both stbs and return to PRESENT.
- DONE: `done`=1 for one cycle, then go to LOAD (new job).
- Acks that arrive while the matching stb is low are ignored.
- Both acks arriving in the same cycle complete the pair in one edge.
- Data is opaque: no arithmetic on elements. Counters are unsigned and wrap only as described.

## Timing
- Reset values:
  - State is LOAD.
  - `in_i_ack`=0; it rises the first cycle after `rst` deasserts.
  - `row_o_stb`, `column_o_stb`, `done`, `pair_i`, `pair_j`, `row`, `column` are all 0.
  - Storage contents are not reset.
- Last load word accepted at edge t: both stbs are 1 in cycle t+1 and `in_i_ack`=0 from t+1.
- Ack sampled high with its stb at edge t: that stb is 0 from t+1.
- Both acks sampled low at edge t in WAIT_DROP: next pair and stbs are valid from t+1.
- `rst` mid-operation aborts on that edge to reset values; a partially issued job is discarded.

## Configuration
- `MATRIX_FEEDER_KEEP_B_EN`:
  - Defined: a `b_valid` flag is set once B is fully loaded and cleared only by `rst`. While it is set, LOAD accepts only N² words (A), and B is reused across jobs.
  - Undefined: every job loads 2N² words; there is no `b_valid` flag.

## Structure
- Shared package `matrix_pkg`: `WORD_WIDTH`=32, the feeder state enum, and a `clog2`-based index width helper.
- Sub-module `matrix_operand_store`:
  - 2N² word register file with a single write port.
  - Combinational read of row i (A) and column j (B) as packed vectors.
- FSM, counters and handshake logic stay in the top.

## Test plan
- N=2, load A=1,2,3,4 and B=0x11,0x12,0x13,0x14, with acks pulsed one cycle after each stb -> pairs (0,0) row={2,1} col={0x13,0x11}; (0,1) col={0x14,0x12}; (1,0) row={4,3}; (1,1). Then `done` pulses once.
- `row_i_ack` at edge t, `column_i_ack` at t+3 -> `row_o_stb` low from t+1, `column_o_stb` low from t+4, and (0,1) is not presented before both are low.
- Acks held high 5 cycles after transfer -> no new stb until the cycle after both are sampled low.
- `in_i_stb` toggling every other cycle -> all 8 words stored correctly; `in_i_ack` drops only after word 8.
- `rst` high during PRESENT of pair (1,0) -> next cycle all outputs are at reset values; a reload of 8 words restarts at (0,0).
- With `MATRIX_FEEDER_KEEP_B_EN`, the second job loads 4 words -> `in_i_ack` drops after word 4 and columns equal the first job's B.
